// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: register-file widths and constants
// shared by the writeback register file and its debug buffer.
package wb_regfile_pkg;
  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam logic [RegBus-1:0]     ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] RegZero  = '0;
endpackage

// File: rtl/wb_dbg_wbuf.sv
// wb_dbg_wbuf: one-entry debug write buffer that yields to
// pipeline writes and escalates to a stall when starved.
module wb_dbg_wbuf
  import wb_regfile_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid_i,
  input  logic [RegAddrBus-1:0] dbg_waddr_i,
  input  logic [RegBus-1:0]     dbg_wdata_i,
  input  logic                  dbg_we_i,
  output logic                  dbg_ready_o,
  output logic                  dbg_stall_req_o,
  output logic                  commit_o,
  output logic                  force_o,
  output logic [RegAddrBus-1:0] commit_addr_o,
  output logic [RegBus-1:0]     commit_data_o
);

  localparam logic [1:0] CntMax = 2'(STARVE_MAX);

  logic                  pend_q, pend_d;
  logic [RegAddrBus-1:0] addr_q, addr_d;
  logic [RegBus-1:0]     data_q, data_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  stall_q, stall_d;
  logic                  blocked;

  always_comb begin
    force_o  = stall_q & pend_q;
    commit_o = pend_q & (~wb_valid_i | force_o);
    blocked  = pend_q & ~commit_o;
    pend_d   = pend_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    if (commit_o) begin
      pend_d  = 1'b0;
      cnt_d   = 2'd0;
      stall_d = 1'b0;
    end else if (blocked) begin
      if (cnt_q < CntMax) cnt_d = cnt_q + 2'd1;
      if (cnt_d == CntMax) stall_d = 1'b1;
    end else if (dbg_we_i) begin
      pend_d = 1'b1;
      addr_d = dbg_waddr_i;
      data_d = dbg_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      addr_q  <= RegZero;
      data_q  <= ZeroWord;
      cnt_q   <= 2'd0;
      stall_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign dbg_ready_o     = ~pend_q;
  assign dbg_stall_req_o = stall_q;
  assign commit_addr_o   = addr_q;
  assign commit_data_o   = data_q;

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file with a buffered debug port.
// Define REGFILE_BYPASS_EN for same-cycle writeback read-through.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int REG_NUM    = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] wb_waddr_i,
  input  logic [RegBus-1:0]     wb_wdata_i,
  input  logic                  wb_we_i,
  input  logic [RegAddrBus-1:0] rs1_raddr_i,
  input  logic [RegAddrBus-1:0] rs2_raddr_i,
  output logic [RegBus-1:0]     rs1_rdata_o,
  output logic [RegBus-1:0]     rs2_rdata_o,
  input  logic [RegAddrBus-1:0] dbg_waddr_i,
  input  logic [RegBus-1:0]     dbg_wdata_i,
  input  logic                  dbg_we_i,
  output logic                  dbg_ready_o,
  input  logic [RegAddrBus-1:0] dbg_raddr_i,
  output logic [RegBus-1:0]     dbg_rdata_o,
  output logic                  dbg_stall_req_o
);

  logic [RegBus-1:0]     regs_q [REG_NUM];
  logic [RegBus-1:0]     dbg_rdata_q;
  logic                  wb_valid;
  logic                  dbg_commit;
  logic                  dbg_force;
  logic [RegAddrBus-1:0] dbg_caddr;
  logic [RegBus-1:0]     dbg_cdata;
  logic                  we;
  logic [RegAddrBus-1:0] waddr;
  logic [RegBus-1:0]     wdata;

  assign wb_valid = wb_we_i && (wb_waddr_i != RegZero);

  wb_dbg_wbuf #(
    .STARVE_MAX (STARVE_MAX)
  ) u_wbuf (
    .clk             (clk),
    .rst             (rst),
    .wb_valid_i      (wb_valid),
    .dbg_waddr_i     (dbg_waddr_i),
    .dbg_wdata_i     (dbg_wdata_i),
    .dbg_we_i        (dbg_we_i),
    .dbg_ready_o     (dbg_ready_o),
    .dbg_stall_req_o (dbg_stall_req_o),
    .commit_o        (dbg_commit),
    .force_o         (dbg_force),
    .commit_addr_o   (dbg_caddr),
    .commit_data_o   (dbg_cdata)
  );

  // A forced debug commit drops the pipeline write; upstream replays it.
  always_comb begin
    we    = dbg_commit | (wb_valid & ~dbg_force);
    waddr = dbg_commit ? dbg_caddr : wb_waddr_i;
    wdata = dbg_commit ? dbg_cdata : wb_wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= ZeroWord;
      dbg_rdata_q <= ZeroWord;
    end else begin
      if (we && (waddr != RegZero)) regs_q[waddr] <= wdata;
      dbg_rdata_q <= (dbg_raddr_i == RegZero) ?
                     ZeroWord : regs_q[dbg_raddr_i];
    end
  end

  always_comb begin
    rs1_rdata_o = (rs1_raddr_i == RegZero) ?
                  ZeroWord : regs_q[rs1_raddr_i];
    rs2_rdata_o = (rs2_raddr_i == RegZero) ?
                  ZeroWord : regs_q[rs2_raddr_i];
`ifdef REGFILE_BYPASS_EN
    if (wb_we_i && (rs1_raddr_i != RegZero) &&
        (rs1_raddr_i == wb_waddr_i))
      rs1_rdata_o = wb_wdata_i;
    if (wb_we_i && (rs2_raddr_i != RegZero) &&
        (rs2_raddr_i == wb_waddr_i))
      rs2_rdata_o = wb_wdata_i;
`endif
  end

  assign dbg_rdata_o = dbg_rdata_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scenarios plus randomized traffic
// checked against a behavioural register-file model.
module tb_wb_regfile;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        wb_we_i;
  logic [4:0]  rs1_raddr_i, rs2_raddr_i;
  logic [31:0] rs1_rdata_o, rs2_rdata_o;
  logic [4:0]  dbg_waddr_i;
  logic [31:0] dbg_wdata_i;
  logic        dbg_we_i;
  logic        dbg_ready_o;
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;
  logic        dbg_stall_req_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [32];
  bit          m_pend;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;
  int          m_wait;
  bit          m_stall;
  logic [31:0] m_dbgrd;

  wb_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .wb_waddr_i      (wb_waddr_i),
    .wb_wdata_i      (wb_wdata_i),
    .wb_we_i         (wb_we_i),
    .rs1_raddr_i     (rs1_raddr_i),
    .rs2_raddr_i     (rs2_raddr_i),
    .rs1_rdata_o     (rs1_rdata_o),
    .rs2_rdata_o     (rs2_rdata_o),
    .dbg_waddr_i     (dbg_waddr_i),
    .dbg_wdata_i     (dbg_wdata_i),
    .dbg_we_i        (dbg_we_i),
    .dbg_ready_o     (dbg_ready_o),
    .dbg_raddr_i     (dbg_raddr_i),
    .dbg_rdata_o     (dbg_rdata_o),
    .dbg_stall_req_o (dbg_stall_req_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we_i && wb_waddr_i == a) return wb_wdata_i;
`endif
    return m_reg[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pend  = 0;
    m_pa    = '0;
    m_pd    = '0;
    m_wait  = 0;
    m_stall = 0;
    m_dbgrd = 32'd0;
  endtask

  // Effect of one rising edge given the current inputs.
  task automatic model_edge();
    bit wbv;
    wbv = wb_we_i && wb_waddr_i != 5'd0;
    m_dbgrd = (dbg_raddr_i == 5'd0) ? 32'd0 : m_reg[dbg_raddr_i];
    if (m_pend && (!wbv || m_stall)) begin
      if (m_pa != 5'd0) m_reg[m_pa] = m_pd;
      m_pend  = 0;
      m_wait  = 0;
      m_stall = 0;
    end else begin
      if (wbv) m_reg[wb_waddr_i] = wb_wdata_i;
      if (m_pend) begin
        if (m_wait < STARVE) m_wait++;
        if (m_wait == STARVE) m_stall = 1;
      end else if (dbg_we_i) begin
        m_pend = 1;
        m_pa   = dbg_waddr_i;
        m_pd   = dbg_wdata_i;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we_i     = 0;
    wb_waddr_i  = '0;
    wb_wdata_i  = '0;
    dbg_we_i    = 0;
    dbg_waddr_i = '0;
    dbg_wdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rs1_raddr_i = 5'd1;
    rs2_raddr_i = 5'd31;
    dbg_raddr_i = 5'd2;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (dbg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=1", dbg_ready_o);
    end
    if (dbg_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got=%b exp=0", dbg_stall_req_o);
    end
    if (dbg_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_dbg_rdata got=%h exp=0", dbg_rdata_o);
    end
    if (rs1_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_rs1 got=%h exp=0", rs1_rdata_o);
    end
    if (rs2_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_rs2 got=%h exp=0", rs2_rdata_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wb_write();
    logic [31:0] exp_now;
    wb_we_i = 1;
    wb_waddr_i = 5'd5;
    wb_wdata_i = 32'hDEADBEEF;
    rs1_raddr_i = 5'd5;
    #1;
    exp_now = m_read(5'd5);
    checks++;
    if (rs1_rdata_o !== exp_now) begin
      errors++;
      $display("FAIL wb_same_cycle got=%h exp=%h", rs1_rdata_o, exp_now);
    end
    tick();
    wb_we_i = 0;
    #1;
    checks++;
    if (rs1_rdata_o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_x5 got=%h exp=deadbeef", rs1_rdata_o);
    end
  endtask

  task automatic test_x0();
    wb_we_i = 1;
    wb_waddr_i = 5'd0;
    wb_wdata_i = 32'h1234;
    rs1_raddr_i = 5'd0;
    rs2_raddr_i = 5'd0;
    dbg_raddr_i = 5'd0;
    tick();
    wb_we_i = 0;
    tick();
    checks += 3;
    if (rs1_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_rs1 got=%h exp=0", rs1_rdata_o);
    end
    if (rs2_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_rs2 got=%h exp=0", rs2_rdata_o);
    end
    if (dbg_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL x0_dbg got=%h exp=0", dbg_rdata_o);
    end
  endtask

  task automatic test_dbg_write();
    idle_inputs();
    dbg_we_i = 1;
    dbg_waddr_i = 5'd7;
    dbg_wdata_i = 32'h55;
    rs1_raddr_i = 5'd7;
    tick();
    dbg_we_i = 0;
    #1;
    checks++;
    if (dbg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL dbg_busy got=%b exp=0", dbg_ready_o);
    end
    tick();
    checks += 2;
    if (dbg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL dbg_ready_back got=%b exp=1", dbg_ready_o);
    end
    if (rs1_rdata_o !== 32'h55) begin
      errors++;
      $display("FAIL dbg_x7 got=%h exp=55", rs1_rdata_o);
    end
  endtask

  task automatic test_same_reg();
    idle_inputs();
    dbg_we_i = 1;
    dbg_waddr_i = 5'd7;
    dbg_wdata_i = 32'hAA;
    wb_we_i = 1;
    wb_waddr_i = 5'd7;
    wb_wdata_i = 32'hBB;
    rs1_raddr_i = 5'd7;
    tick();
    dbg_we_i = 0;
    tick();
    wb_we_i = 0;
    #1;
    checks += 2;
    if (rs1_rdata_o !== 32'hBB) begin
      errors++;
      $display("FAIL same_reg_wb got=%h exp=bb", rs1_rdata_o);
    end
    if (dbg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL same_reg_pend got=%b exp=0", dbg_ready_o);
    end
    tick();
    checks++;
    if (rs1_rdata_o !== 32'hAA) begin
      errors++;
      $display("FAIL same_reg_final got=%h exp=aa", rs1_rdata_o);
    end
  endtask

  task automatic test_starve();
    logic [31:0] v [5];
    for (int i = 0; i < 5; i++) v[i] = $urandom;
    idle_inputs();
    rs1_raddr_i = 5'd9;
    rs2_raddr_i = 5'd3;
    dbg_we_i = 1;
    dbg_waddr_i = 5'd9;
    dbg_wdata_i = 32'h77;
    wb_we_i = 1;
    wb_waddr_i = 5'd3;
    wb_wdata_i = v[0];
    tick();
    dbg_we_i = 0;
    for (int c = 1; c <= 3; c++) begin
      wb_wdata_i = v[c];
      tick();
      checks++;
      if (dbg_stall_req_o !== (c == 3)) begin
        errors++;
        $display("FAIL starve_stall_c%0d got=%b exp=%b",
                 c, dbg_stall_req_o, (c == 3));
      end
    end
    wb_wdata_i = v[4];
    tick();
    wb_we_i = 0;
    #1;
    checks += 4;
    if (dbg_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL starve_release got=%b exp=0", dbg_stall_req_o);
    end
    if (dbg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL starve_ready got=%b exp=1", dbg_ready_o);
    end
    if (rs1_rdata_o !== 32'h77) begin
      errors++;
      $display("FAIL starve_x9 got=%h exp=77", rs1_rdata_o);
    end
    if (rs2_rdata_o !== v[3]) begin
      errors++;
      $display("FAIL starve_drop_x3 got=%h exp=%h", rs2_rdata_o, v[3]);
    end
  endtask

  task automatic test_reset_pending();
    idle_inputs();
    wb_we_i = 1;
    wb_waddr_i = 5'd12;
    wb_wdata_i = 32'h1111;
    tick();
    wb_we_i = 1;
    wb_waddr_i = 5'd4;
    dbg_we_i = 1;
    dbg_waddr_i = 5'd12;
    dbg_wdata_i = 32'hCAFE;
    rs1_raddr_i = 5'd12;
    dbg_raddr_i = 5'd12;
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks += 4;
    if (dbg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstp_ready got=%b exp=1", dbg_ready_o);
    end
    if (dbg_stall_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rstp_stall got=%b exp=0", dbg_stall_req_o);
    end
    if (dbg_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL rstp_dbg_rdata got=%h exp=0", dbg_rdata_o);
    end
    if (rs1_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL rstp_rs1 got=%h exp=0", rs1_rdata_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (rs1_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL rstp_x12 got=%h exp=0", rs1_rdata_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    bit heavy;
    for (int n = 0; n < 400; n++) begin
      heavy = ((n / 40) % 2) == 1;
      wb_we_i = heavy ? ($urandom_range(0, 9) < 9)
                      : ($urandom_range(0, 1) == 1);
      wb_waddr_i  = 5'($urandom);
      wb_wdata_i  = $urandom;
      dbg_we_i    = ($urandom_range(0, 2) == 0);
      dbg_waddr_i = 5'($urandom);
      dbg_wdata_i = $urandom;
      rs1_raddr_i = 5'($urandom);
      rs2_raddr_i = 5'($urandom);
      dbg_raddr_i = 5'($urandom);
      #1;
      e1 = m_read(rs1_raddr_i);
      e2 = m_read(rs2_raddr_i);
      checks += 2;
      if (rs1_rdata_o !== e1) begin
        errors++;
        $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, rs1_rdata_o, e1);
      end
      if (rs2_rdata_o !== e2) begin
        errors++;
        $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, rs2_rdata_o, e2);
      end
      tick();
      checks += 3;
      if (dbg_ready_o !== !m_pend) begin
        errors++;
        $display("FAIL rnd_ready n=%0d got=%b exp=%b",
                 n, dbg_ready_o, !m_pend);
      end
      if (dbg_stall_req_o !== m_stall) begin
        errors++;
        $display("FAIL rnd_stall n=%0d got=%b exp=%b",
                 n, dbg_stall_req_o, m_stall);
      end
      if (dbg_rdata_o !== m_dbgrd) begin
        errors++;
        $display("FAIL rnd_dbg_rdata n=%0d got=%h exp=%h",
                 n, dbg_rdata_o, m_dbgrd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_x0();
    test_dbg_write();
    test_same_reg();
    test_starve();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
